// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst and data requesters: fixed priority (data first),
// grant held until address handshake, in-order owner FIFO steers responses, flushed fetches dropped.
module sram_req_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  input  logic             flush,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic             busy,
  output logic             proto_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic             lock_vld_q, lock_vld_d;
  logic             lock_owner_q, lock_owner_d;
  logic             lock_disc_q, lock_disc_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d, own_q, own_d, disc_q, disc_d;
  logic             proto_err_q, proto_err_d;

  logic owner, full, xfer, pop, push_disc, head_own, head_disc;

  // Owner encoding: 1 = data, 0 = inst. A held lock overrides live priority.
  always_comb begin
    owner        = lock_vld_q ? lock_owner_q : data_req;
    full         = (count_q == FULL_CNT);
    m_req        = lock_vld_q | ((inst_req | data_req) & ~full);
    xfer         = m_req & m_addr_ok;
    m_wr         = owner ? data_wr    : inst_wr;
    m_size       = owner ? data_size  : inst_size;
    m_addr       = owner ? data_addr  : inst_addr;
    m_wdata      = owner ? data_wdata : inst_wdata;
    inst_addr_ok = xfer & ~owner;
    data_addr_ok = xfer & owner;
    head_own     = own_q[rd_ptr_q];
    head_disc    = disc_q[rd_ptr_q];
    pop          = m_data_ok & (count_q != '0);
    inst_data_ok = pop & ~head_own & ~head_disc & ~flush;
    data_data_ok = pop & head_own;
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
    push_disc    = ~owner & (flush | (lock_vld_q & lock_disc_q));
    busy         = (count_q != '0);
    proto_err    = proto_err_q;
  end

  always_comb begin
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    lock_disc_d  = lock_disc_q;
    if (xfer) begin
      lock_vld_d  = 1'b0;
      lock_disc_d = 1'b0;
    end else if (m_req) begin
      lock_vld_d   = 1'b1;
      lock_owner_d = owner;
      lock_disc_d  = ~owner & ((lock_vld_q & lock_disc_q) | flush);
    end

    vld_d  = vld_q;
    own_d  = own_q;
    disc_d = disc_q;
    // A flush poisons every queued fetch; the response still pops but is not forwarded.
    if (flush) disc_d = disc_q | (vld_q & ~own_q);
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (xfer) begin
      vld_d[wr_ptr_q]  = 1'b1;
      own_d[wr_ptr_q]  = owner;
      disc_d[wr_ptr_q] = push_disc;
    end

    wr_ptr_d = xfer ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({xfer, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    proto_err_d = proto_err_q | (m_data_ok & (count_q == '0));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q   <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_disc_q  <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      vld_q        <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      lock_disc_q  <= lock_disc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      vld_q        <= vld_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Owner/discard payload is always written on push before it is read.
  always_ff @(posedge clk) begin
    own_q  <= own_d;
    disc_q <= disc_d;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: cycle vector table for request/grant behaviour plus
// a response scoreboard, and hand sequences for reset, proto_err and async reset.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr, flush;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, proto_err;

  sram_req_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ireq, dreq, maok, mdok, fl;
    logic [31:0] iaddr, daddr, rdata;
    logic        emreq, eiaok, edaok;
    logic [31:0] emaddr;
  } vec_t;

  typedef struct packed {
    logic own_d;
    logic disc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add(input logic i, d, ma, md, fl, input logic [31:0] ia, da, rd,
                     input logic em, ei, ed, input logic [31:0] ema);
    vec_t v;
    v = '{ireq: i, dreq: d, maok: ma, mdok: md, fl: fl, iaddr: ia, daddr: da, rdata: rd,
          emreq: em, eiaok: ei, edaok: ed, emaddr: ema};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0; flush = 0;
    m_rdata = '0; inst_addr = '0; data_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    sb_t  e;
    logic pend;
    logic exp_i, exp_d;

    inst_wr = 0; inst_size = 2'd2; inst_wdata = 32'h0;
    data_wr = 1; data_size = 2'd1; data_wdata = 32'hDEADBEEF;
    idle_inputs();
    resetn = 0;
    pend = 0;

    // simultaneous requests: data first, then inst; responses D then I
    add(1,1,1,0,0, 32'h100,32'h200,32'h0,        1,0,1, 32'h200);
    add(1,0,1,0,0, 32'h100,32'h200,32'h0,        1,1,0, 32'h100);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h11111111, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h22222222, 0,0,0, 32'h0);
    // inst locked for 3 cycles while data rises: grant must stay with inst
    add(1,0,0,0,0, 32'h104,32'h204,32'h0,        1,0,0, 32'h104);
    add(1,1,0,0,0, 32'h104,32'h204,32'h0,        1,0,0, 32'h104);
    add(1,1,0,0,0, 32'h104,32'h204,32'h0,        1,0,0, 32'h104);
    add(1,1,1,0,0, 32'h104,32'h204,32'h0,        1,1,0, 32'h104);
    add(0,1,1,0,0, 32'h104,32'h204,32'h0,        1,0,1, 32'h204);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'hA5A50001, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'hA5A50002, 0,0,0, 32'h0);
    // fill to DEPTH, fifth request blocked until one response returns
    add(1,0,1,0,0, 32'h108,32'h0,  32'h0,        1,1,0, 32'h108);
    add(1,0,1,0,0, 32'h10C,32'h0,  32'h0,        1,1,0, 32'h10C);
    add(1,0,1,0,0, 32'h110,32'h0,  32'h0,        1,1,0, 32'h110);
    add(1,0,1,0,0, 32'h114,32'h0,  32'h0,        1,1,0, 32'h114);
    add(1,0,1,0,0, 32'h118,32'h0,  32'h0,        0,0,0, 32'h0);
    add(1,0,1,1,0, 32'h118,32'h0,  32'h33330001, 0,0,0, 32'h0);
    add(1,0,1,0,0, 32'h118,32'h0,  32'h0,        1,1,0, 32'h118);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h33330002, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h33330003, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h33330004, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h33330005, 0,0,0, 32'h0);
    // I,D,I in flight, flush, then three responses: only data forwarded
    add(1,0,1,0,0, 32'h120,32'h0,  32'h0,        1,1,0, 32'h120);
    add(0,1,1,0,0, 32'h0,  32'h220,32'h0,        1,0,1, 32'h220);
    add(1,0,1,0,0, 32'h124,32'h0,  32'h0,        1,1,0, 32'h124);
    add(0,0,0,0,1, 32'h0,  32'h0,  32'h0,        0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h44440001, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h44440002, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h44440003, 0,0,0, 32'h0);
    // flush while inst is locked: accepted later, its response dropped
    add(1,0,0,0,0, 32'h130,32'h0,  32'h0,        1,0,0, 32'h130);
    add(1,0,0,0,1, 32'h130,32'h0,  32'h0,        1,0,0, 32'h130);
    add(1,0,0,0,0, 32'h130,32'h0,  32'h0,        1,0,0, 32'h130);
    add(1,0,1,0,0, 32'h130,32'h0,  32'h0,        1,1,0, 32'h130);
    add(1,0,1,0,0, 32'h134,32'h0,  32'h0,        1,1,0, 32'h134);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h55550001, 0,0,0, 32'h0);
    add(0,0,0,1,0, 32'h0,  32'h0,  32'h55550002, 0,0,0, 32'h0);

    // reset state
    #3;
    chk("rst m_req", m_req, 0);
    chk("rst busy", busy, 0);
    chk("rst proto_err", proto_err, 0);
    chk("rst inst_addr_ok", inst_addr_ok, 0);
    chk("rst data_addr_ok", data_addr_ok, 0);
    #9 resetn = 1;

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(posedge clk); #1;
      inst_req = v.ireq; data_req = v.dreq; m_addr_ok = v.maok; m_data_ok = v.mdok;
      flush = v.fl; inst_addr = v.iaddr; data_addr = v.daddr; m_rdata = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d m_req", k), m_req, v.emreq);
      chk($sformatf("v%0d inst_addr_ok", k), inst_addr_ok, v.eiaok);
      chk($sformatf("v%0d data_addr_ok", k), data_addr_ok, v.edaok);
      if (v.emreq) begin
        chk($sformatf("v%0d m_addr", k), m_addr, v.emaddr);
        chk($sformatf("v%0d m_size", k), m_size, v.emaddr[9] ? 2'd1 : 2'd2);
        chk($sformatf("v%0d m_wr", k), m_wr, v.emaddr[9]);
        chk($sformatf("v%0d m_wdata", k), m_wdata, v.emaddr[9] ? 32'hDEADBEEF : 32'h0);
      end
      if (v.fl) begin
        foreach (sb[j]) if (!sb[j].own_d) sb[j].disc = 1'b1;
        if (v.ireq && !v.eiaok) pend = 1'b1;
      end
      exp_i = 0; exp_d = 0;
      if (v.mdok && sb.size() > 0) begin
        e = sb.pop_front();
        exp_d = e.own_d;
        exp_i = !e.own_d && !e.disc;
      end
      chk($sformatf("v%0d inst_data_ok", k), inst_data_ok, exp_i);
      chk($sformatf("v%0d data_data_ok", k), data_data_ok, exp_d);
      if (exp_i) chk($sformatf("v%0d inst_rdata", k), inst_rdata, v.rdata);
      if (exp_d) chk($sformatf("v%0d data_rdata", k), data_rdata, v.rdata);
      if (v.eiaok) begin
        sb.push_back('{own_d: 1'b0, disc: v.fl | pend});
        pend = 1'b0;
      end
      if (v.edaok) sb.push_back('{own_d: 1'b1, disc: 1'b0});
    end

    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("drained scoreboard", sb.size(), 0);
    chk("drained busy", busy, 0);
    chk("no proto_err yet", proto_err, 0);

    // stray response with empty FIFO
    @(posedge clk); #1;
    m_data_ok = 1; m_rdata = 32'h66660001;
    @(negedge clk);
    chk("stray inst_data_ok", inst_data_ok, 0);
    chk("stray data_data_ok", data_data_ok, 0);
    @(posedge clk); #1;
    m_data_ok = 0;
    @(negedge clk);
    chk("proto_err set", proto_err, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("proto_err sticky", proto_err, 1);

    // two reads in flight, then asynchronous reset mid-cycle
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      inst_req = 1; m_addr_ok = 1; inst_addr = 32'h140 + 32'(k * 4);
      @(negedge clk);
      chk($sformatf("pre-reset inst_addr_ok %0d", k), inst_addr_ok, 1);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("pre-reset busy", busy, 1);
    #2 resetn = 0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset proto_err", proto_err, 0);
    chk("async reset m_req", m_req, 0);
    @(posedge clk); #1;
    resetn = 1;

    // fresh transaction after reset behaves normally
    inst_req = 1; m_addr_ok = 1; inst_addr = 32'h150;
    @(negedge clk);
    chk("post-reset inst_addr_ok", inst_addr_ok, 1);
    chk("post-reset m_addr", m_addr, 32'h150);
    @(posedge clk); #1;
    idle_inputs();
    m_data_ok = 1; m_rdata = 32'h77770001;
    @(negedge clk);
    chk("post-reset inst_data_ok", inst_data_ok, 1);
    chk("post-reset inst_rdata", inst_rdata, 32'h77770001);
    chk("post-reset proto_err", proto_err, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("post-reset busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
